// File: rtl/conv_accum_ctrl.sv
// rtl/conv_accum_ctrl.sv - shared adder-tree sequencer with per-group channel accumulation and bias (optional CONV_ACCUM_RELU_EN clamp)

// Two-stage pipelined adder tree with a fixed latency of two cycles.
// Stage 1 sums groups of GROUP elements. Stage 2 sums the group partials.
module conv_accum_tree #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_INPUTS = 27,
  parameter int OUT_WIDTH  = 21,
  parameter int GROUP      = 6
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DATA_WIDTH*NUM_INPUTS-1:0] i_data,
  input  logic                             i_valid,
  output logic [OUT_WIDTH-1:0]             o_data,
  output logic                             o_valid
);
  localparam int NUM_GRP = (NUM_INPUTS + GROUP - 1) / GROUP;

  logic [DATA_WIDTH-1:0] w_elem;
  logic [OUT_WIDTH-1:0]  w_part [NUM_GRP];
  logic [OUT_WIDTH-1:0]  r_part [NUM_GRP];
  logic                  r_valid1;
  logic [OUT_WIDTH-1:0]  w_total;
  logic [OUT_WIDTH-1:0]  r_total;
  logic                  r_valid2;

  // Sign-extend every element and fold it into its group's partial sum
  always_comb begin
    w_elem = '0;
    for (int g = 0; g < NUM_GRP; g++) begin
      w_part[g] = '0;
    end
    for (int k = 0; k < NUM_INPUTS; k++) begin
      w_elem = i_data[k*DATA_WIDTH +: DATA_WIDTH];
      w_part[k/GROUP] = w_part[k/GROUP]
                      + {{(OUT_WIDTH-DATA_WIDTH){w_elem[DATA_WIDTH-1]}}, w_elem};
    end
  end

  // Stage 1 register: the valid bit resets so in-flight beats are dropped on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid1 <= 1'b0;
      for (int g = 0; g < NUM_GRP; g++) begin
        r_part[g] <= '0;
      end
    end else begin
      r_valid1 <= i_valid;
      for (int g = 0; g < NUM_GRP; g++) begin
        r_part[g] <= w_part[g];
      end
    end
  end

  // Final reduction of the group partials
  always_comb begin
    w_total = '0;
    for (int g = 0; g < NUM_GRP; g++) begin
      w_total = w_total + r_part[g];
    end
  end

  // Stage 2 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid2 <= 1'b0;
      r_total  <= '0;
    end else begin
      r_valid2 <= r_valid1;
      r_total  <= w_total;
    end
  end

  assign o_data  = r_total;
  assign o_valid = r_valid2;
endmodule

module conv_accum_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_INPUTS = 27,
  parameter int ACC_WIDTH  = 32,
  parameter int MAX_CH     = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DATA_WIDTH*NUM_INPUTS-1:0] s_data,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [$clog2(MAX_CH+1)-1:0]      cfg_num_ch,
  input  logic [DATA_WIDTH-1:0]            cfg_bias,
  output logic [ACC_WIDTH-1:0]             m_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic                             busy
);
  localparam int CW     = $clog2(MAX_CH+1);
  localparam int TREE_W = DATA_WIDTH + $clog2(NUM_INPUTS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_state_n;
  logic [CW-1:0]         r_issue_cnt;
  logic [CW-1:0]         r_res_cnt;
  logic [CW-1:0]         r_num_ch;
  logic [DATA_WIDTH-1:0] r_bias;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [ACC_WIDTH-1:0]  r_m_data;
  logic                  r_m_valid;

  logic                  w_accept;
  logic                  w_first;
  logic [CW-1:0]         w_cfg_num_ch;
  logic [CW-1:0]         w_num_ch;
  logic [DATA_WIDTH-1:0] w_bias;
  logic                  w_tree_ov;
  logic [TREE_W-1:0]     w_tree_od;
  logic                  w_last_res;
  logic [ACC_WIDTH-1:0]  w_base;
  logic [ACC_WIDTH-1:0]  w_sum;
  logic [ACC_WIDTH-1:0]  w_final;

  assign s_ready      = (r_state == S_IDLE) || (r_state == S_ISSUE);
  assign w_accept     = s_valid & s_ready;
  assign w_first      = (r_state == S_IDLE) & w_accept;
  assign w_cfg_num_ch = (cfg_num_ch == '0) ? CW'(1) : cfg_num_ch;

  // Bypass the freshly sampled config so a zero-latency tree sees the right group size and bias
  assign w_num_ch = w_first ? w_cfg_num_ch : r_num_ch;
  assign w_bias   = w_first ? cfg_bias : r_bias;

  conv_accum_tree #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_INPUTS (NUM_INPUTS),
    .OUT_WIDTH  (TREE_W)
  ) u_tree (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_data  (s_data),
    .i_valid (w_accept),
    .o_data  (w_tree_od),
    .o_valid (w_tree_ov)
  );

  assign w_last_res = w_tree_ov && (r_res_cnt == (w_num_ch - CW'(1)));
  assign w_base     = (r_res_cnt == '0)
                    ? {{(ACC_WIDTH-DATA_WIDTH){w_bias[DATA_WIDTH-1]}}, w_bias}
                    : r_acc;
  assign w_sum      = w_base + {{(ACC_WIDTH-TREE_W){w_tree_od[TREE_W-1]}}, w_tree_od};

  // Optional clamp of negative results, applied in the output register stage
  always_comb begin
    w_final = w_sum;
`ifdef CONV_ACCUM_RELU_EN
    if (w_sum[ACC_WIDTH-1]) begin
      w_final = '0;
    end
`endif
  end

  // Next-state logic; the final tree result overrides every other transition
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_n = (w_cfg_num_ch == CW'(1)) ? S_DRAIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_accept && (r_issue_cnt == (r_num_ch - CW'(1)))) begin
          w_state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_state_n = S_DRAIN;
      end
      default: begin
        if (m_ready) begin
          w_state_n = S_IDLE;
        end
      end
    endcase
    if (w_last_res && (r_state != S_OUT)) begin
      w_state_n = S_OUT;
    end
  end

  // State register and beat/config bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_issue_cnt <= '0;
      r_num_ch    <= '0;
      r_bias      <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_first) begin
        r_issue_cnt <= CW'(1);
        r_num_ch    <= w_cfg_num_ch;
        r_bias      <= cfg_bias;
      end else if (w_accept) begin
        r_issue_cnt <= r_issue_cnt + CW'(1);
      end
    end
  end

  // Accumulate tree results and publish the group sum on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_res_cnt <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
    end else begin
      if (w_tree_ov) begin
        if (w_last_res) begin
          r_res_cnt <= '0;
          r_m_data  <= w_final;
          r_m_valid <= 1'b1;
        end else begin
          r_acc     <= w_sum;
          r_res_cnt <= r_res_cnt + CW'(1);
        end
      end
      if ((r_state == S_OUT) && m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign m_data  = r_m_data;
  assign m_valid = r_m_valid;
  assign busy    = (r_state != S_IDLE);
endmodule

// File: tb/tb_conv_accum_ctrl.sv
// tb/tb_conv_accum_ctrl.sv - directed self-checking bench for conv_accum_ctrl
`timescale 1ns/1ps
module tb_conv_accum_ctrl;
  localparam int DW = 16;
  localparam int NI = 27;
  localparam int AW = 32;

  logic             clk;
  logic             rst_n;
  logic [DW*NI-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic [6:0]       cfg_num_ch;
  logic [DW-1:0]    cfg_bias;
  logic [AW-1:0]    m_data;
  logic             m_valid;
  logic             m_ready;
  logic             busy;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int cyc;
  int hits;

  conv_accum_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .cfg_num_ch (cfg_num_ch),
    .cfg_bias   (cfg_bias),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW*NI-1:0] fill(input logic [DW-1:0] v);
    logic [DW*NI-1:0] r;
    for (int k = 0; k < NI; k++) r[k*DW +: DW] = v;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one beat at a negedge and return at the negedge after it was taken
  task automatic send_beat(input logic [DW-1:0] v);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = fill(v);
    while (!s_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("beat_timeout", {31'd0, s_ready}, 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_mvalid(output int c);
    c = 0;
    while (!m_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    cfg_num_ch = '0; cfg_bias = '0;
    repeat (2) @(negedge clk);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: three back-to-back beats of ones, bias 5 -> 3*27+5 = 86
    cfg_num_ch = 7'd3; cfg_bias = 16'd5;
    send_beat(16'd1);
    chk("t1_busy_beat1", {31'd0, busy}, 32'd1);
    send_beat(16'd1);
    send_beat(16'd1);
    chk("t1_drain_s_ready", {31'd0, s_ready}, 32'd0);
    chk("t1_busy_drain", {31'd0, busy}, 32'd1);
    wait_mvalid(cyc);
    chk("t1_latency", cyc, 32'd2);
    chk("t1_m_data", m_data, 32'd86);
    chk("t1_busy_out", {31'd0, busy}, 32'd1);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("t1_m_valid_clr", {31'd0, m_valid}, 32'd0);
    chk("t1_s_ready_after", {31'd0, s_ready}, 32'd1);
    chk("t1_busy_idle", {31'd0, busy}, 32'd0);

    // 2: single beat of -2 -> -54, or 0 with the clamp
    cfg_num_ch = 7'd1; cfg_bias = 16'd0;
    send_beat(16'hFFFE);
    chk("t2_single_drain", {31'd0, s_ready}, 32'd0);
    wait_mvalid(cyc);
`ifdef CONV_ACCUM_RELU_EN
    chk("t2_m_data", m_data, 32'd0);
`else
    chk("t2_m_data", m_data, 32'hFFFFFFCA);
`endif
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;

    // 3: cfg_num_ch=0 treated as 1; 27*32767-1 = 884708
    cfg_num_ch = 7'd0; cfg_bias = 16'hFFFF;
    send_beat(16'h7FFF);
    chk("t3_zero_as_one", {31'd0, s_ready}, 32'd0);
    wait_mvalid(cyc);
    chk("t3_latency", cyc, 32'd2);
    chk("t3_m_data", m_data, 32'd884708);

    // 4: back-pressure in OUT with s_valid held high
    s_valid = 1'b1;
    s_data  = fill(16'd9);
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      if (m_data !== 32'd884708 || s_ready !== 1'b0 || m_valid !== 1'b1 || (s_valid & s_ready)) hits++;
      @(negedge clk);
    end
    chk("t4_hold_violations", hits, 32'd0);
    chk("t4_m_data_held", m_data, 32'd884708);
    m_ready = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    m_ready = 1'b0;
    chk("t4_s_ready_next", {31'd0, s_ready}, 32'd1);
    chk("t4_m_valid_clr", {31'd0, m_valid}, 32'd0);

    // 5: four beats with gaps, config changed after beat 1 -> 10+27*(1+2+3+4) = 280
    cfg_num_ch = 7'd4; cfg_bias = 16'd10;
    send_beat(16'd1);
    cfg_num_ch = 7'd2; cfg_bias = 16'hFF9C;
    repeat (2) @(negedge clk);
    send_beat(16'd2);
    repeat (3) @(negedge clk);
    chk("t5_no_early_out", {31'd0, m_valid}, 32'd0);
    chk("t5_still_issue", {31'd0, s_ready}, 32'd1);
    send_beat(16'd3);
    @(negedge clk);
    send_beat(16'd4);
    wait_mvalid(cyc);
    chk("t5_m_data", m_data, 32'd280);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      if (m_valid) hits++;
      @(negedge clk);
    end
    chk("t5_single_m_valid", hits, 32'd0);

    // 6: reset after beat 2 of 4, then a clean group 27*7-27+3 = 165
    cfg_num_ch = 7'd4; cfg_bias = 16'd0;
    send_beat(16'd5);
    send_beat(16'd5);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_s_ready", {31'd0, s_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (m_valid || busy) hits++;
    end
    chk("t6_no_partial", hits, 32'd0);
    cfg_num_ch = 7'd2; cfg_bias = 16'd3;
    send_beat(16'd7);
    send_beat(16'hFFFF);
    wait_mvalid(cyc);
    chk("t6_clean_m_data", m_data, 32'd165);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("t6_idle_after", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
